// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM model/controller each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter grant state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority, but a completed data grant hands the next contested
// grant to the fetch side so neither requester starves. Each grant is
// bounded by a wait counter; timeouts and RAM errors set a sticky memerr.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  // instruction fetch port
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  // data port
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  // RAM port
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  // sticky error
  output logic      memerr
);

  arb_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_was_data_q, last_was_data_d;
  logic       memerr_q, memerr_d;

  logic       dreq;
  logic       req;
  logic [8:0] cnt_inc;

  // Next-state and output decode; RAM port and waits follow the current grant.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_was_data_d = last_was_data_q;
    memerr_d        = memerr_q;
    req             = 1'b0;
    iwait           = 1'b1;
    dwait           = 1'b1;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = '0;
    ramstore        = '0;

    dreq    = dREN | dWEN;
    cnt_inc = {1'b0, cnt_q} + 9'd1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Fetch wins a contested cycle only right after a completed data grant.
        if (dreq && !(iREN && last_was_data_q)) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT, IGRANT: begin
        if (state_q == DGRANT) begin
          req      = dreq;
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          dwait    = ~(req && (ramstate == ACCESS));
        end else begin
          req     = iREN;
          ramaddr = iaddr;
          ramREN  = 1'b1;
          iwait   = ~(req && (ramstate == ACCESS));
        end

        if (!req) begin
          // Requester gave up: abort without recording a completion.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (ramstate == ERROR) begin
          memerr_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (ramstate == ACCESS) begin
          state_d         = IDLE;
          cnt_d           = '0;
          last_was_data_d = (state_q == DGRANT);
        end else if (32'(cnt_inc) >= TIMEOUT) begin
          memerr_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant FSM, wait counter, alternation bit and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      last_was_data_q <= 1'b0;
      memerr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_was_data_q <= last_was_data_d;
      memerr_q        <= memerr_d;
    end
  end

  assign iload  = ramload;
  assign dload  = ramload;
  assign memerr = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned TO = 4;

  logic      CLK, nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, memerr;
  word_t     iload, dload, ramaddr, ramstore;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .memerr   (memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic      i_ren, d_ren, d_wen;
    ramstate_t rs;
    logic      e_iw, e_dw, e_ren, e_wen, e_err;
    logic      grant;
    word_t     e_addr, e_store;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_iw, input logic e_dw,
                            input logic e_ren, input logic e_wen, input logic e_err,
                            input logic grant, input word_t e_addr, input word_t e_store);
    chk({tag, ".iwait"}, 32'(iwait), 32'(e_iw));
    chk({tag, ".dwait"}, 32'(dwait), 32'(e_dw));
    chk({tag, ".ramREN"}, 32'(ramREN), 32'(e_ren));
    chk({tag, ".ramWEN"}, 32'(ramWEN), 32'(e_wen));
    chk({tag, ".memerr"}, 32'(memerr), 32'(e_err));
    chk({tag, ".iload"}, iload, ramload);
    chk({tag, ".dload"}, dload, ramload);
    if (grant) begin
      chk({tag, ".ramaddr"}, ramaddr, e_addr);
      chk({tag, ".ramstore"}, ramstore, e_store);
    end
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic i, input logic d, input logic w, input ramstate_t rs);
    iREN     = i;
    dREN     = d;
    dWEN     = w;
    ramstate = rs;
  endtask

  // One cycle: apply inputs, check combinational outputs, advance past the edge.
  task automatic cyc(input string tag, input logic i, input logic d, input logic w,
                     input ramstate_t rs, input logic e_iw, input logic e_dw,
                     input logic e_ren, input logic e_wen, input logic e_err,
                     input logic grant, input word_t e_addr, input word_t e_store);
    drive(i, d, w, rs);
    #1;
    check_outs(tag, e_iw, e_dw, e_ren, e_wen, e_err, grant, e_addr, e_store);
    next_cycle();
  endtask

  task automatic do_reset(input string tag);
    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, FREE);
    #1;
    check_outs(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // Behavioural model: owner 0 = nobody, 1 = data, 2 = fetch.
  int m_owner, m_cnt;
  bit m_last_data, m_err;

  initial begin
    iaddr   = 32'h0000_0040;
    daddr   = 32'h0000_0100;
    dstore  = 32'hDEAD_BEEF;
    ramload = 32'hCAFE_F00D;
    nRST    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, FREE);

    //            i  d  w  rs      iw dw rn wn er gr addr          store
    vecs[0]  = '{1, 0, 0, FREE,   1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 0, 0, BUSY,   1, 1, 1, 0, 0, 1, 32'h40,       32'h0};
    vecs[2]  = '{1, 0, 0, BUSY,   1, 1, 1, 0, 0, 1, 32'h40,       32'h0};
    vecs[3]  = '{1, 0, 0, ACCESS, 0, 1, 1, 0, 0, 1, 32'h40,       32'h0};
    vecs[4]  = '{0, 0, 0, FREE,   1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[5]  = '{1, 1, 0, FREE,   1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[6]  = '{1, 1, 0, ACCESS, 1, 0, 1, 0, 0, 1, 32'h100,      32'hDEADBEEF};
    vecs[7]  = '{1, 1, 0, FREE,   1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[8]  = '{1, 1, 0, ACCESS, 0, 1, 1, 0, 0, 1, 32'h40,       32'h0};
    vecs[9]  = '{0, 1, 1, FREE,   1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[10] = '{0, 1, 1, ACCESS, 1, 0, 0, 1, 0, 1, 32'h100,      32'hDEADBEEF};
    vecs[11] = '{0, 1, 0, FREE,   1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[12] = '{0, 1, 0, ERROR,  1, 1, 1, 0, 0, 1, 32'h100,      32'hDEADBEEF};
    vecs[13] = '{0, 0, 0, FREE,   1, 1, 0, 0, 1, 0, 32'h0,        32'h0};

    // Table: lone fetch, contention/alternation, write priority, RAM error.
    do_reset("reset0");
    for (int k = 0; k < 14; k++) begin
      cyc($sformatf("vec%0d", k), vecs[k].i_ren, vecs[k].d_ren, vecs[k].d_wen, vecs[k].rs,
          vecs[k].e_iw, vecs[k].e_dw, vecs[k].e_ren, vecs[k].e_wen, vecs[k].e_err,
          vecs[k].grant, vecs[k].e_addr, vecs[k].e_store);
    end

    // Timeout with RAM stuck BUSY; memerr is sticky until reset.
    do_reset("reset_to");
    cyc("to_req", 0, 1, 0, BUSY, 1, 1, 0, 0, 0, 0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      cyc($sformatf("to_busy%0d", k), 0, 1, 0, BUSY, 1, 1, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF);
    end
    cyc("to_abort", 0, 1, 0, BUSY, 1, 1, 0, 0, 1, 0, '0, '0);
    cyc("to_retry", 0, 1, 0, BUSY, 1, 1, 1, 0, 1, 1, 32'h100, 32'hDEADBEEF);
    cyc("to_drop", 0, 0, 0, FREE, 1, 1, 0, 0, 1, 0, '0, '0);
    cyc("to_hold", 0, 0, 0, FREE, 1, 1, 0, 0, 1, 0, '0, '0);
    do_reset("to_clear");

    // Abort: fetch withdrawn mid-grant records no completion.
    cyc("ab_d0", 0, 1, 0, FREE, 1, 1, 0, 0, 0, 0, '0, '0);
    cyc("ab_d1", 0, 1, 0, ACCESS, 1, 0, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF);
    cyc("ab_i0", 1, 0, 0, FREE, 1, 1, 0, 0, 0, 0, '0, '0);
    cyc("ab_i1", 1, 0, 0, BUSY, 1, 1, 1, 0, 0, 1, 32'h40, 32'h0);
    cyc("ab_drop", 0, 0, 0, BUSY, 1, 1, 1, 0, 0, 1, 32'h40, 32'h0);
    cyc("ab_idle", 0, 1, 0, FREE, 1, 1, 0, 0, 0, 0, '0, '0);
    cyc("ab_dgr", 0, 1, 0, ACCESS, 1, 0, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF);
    cyc("ab_i2", 1, 0, 0, FREE, 1, 1, 0, 0, 0, 0, '0, '0);
    cyc("ab_drop2", 0, 0, 0, BUSY, 1, 1, 1, 0, 0, 1, 32'h40, 32'h0);
    cyc("ab_both0", 1, 1, 0, FREE, 1, 1, 0, 0, 0, 0, '0, '0);
    cyc("ab_both1", 1, 1, 0, ACCESS, 0, 1, 1, 0, 0, 1, 32'h40, 32'h0);

    // Asynchronous reset in the middle of a data write grant.
    do_reset("reset_ar");
    cyc("ar_req", 0, 1, 1, FREE, 1, 1, 0, 0, 0, 0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, BUSY);
    #1;
    check_outs("ar_grant", 1, 1, 0, 1, 0, 1, 32'h100, 32'hDEADBEEF);
    #2;
    nRST = 1'b0;
    #1;
    check_outs("ar_async", 1, 1, 0, 0, 0, 0, '0, '0);
    next_cycle();
    check_outs("ar_held", 1, 1, 0, 0, 0, 0, '0, '0);
    nRST = 1'b1;
    #1;
    check_outs("ar_idle", 1, 1, 0, 0, 0, 0, '0, '0);
    next_cycle();
    check_outs("ar_regrant", 1, 1, 0, 1, 0, 1, 32'h100, 32'hDEADBEEF);

    // Randomized traffic against the behavioural model.
    do_reset("reset_rnd");
    m_owner     = 0;
    m_cnt       = 0;
    m_last_data = 1'b0;
    m_err       = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic  e_iw, e_dw, e_ren, e_wen, grant, rq;
      word_t e_addr, e_store;
      int    r;
      iREN    = ($urandom_range(99) < 60);
      dREN    = ($urandom_range(99) < 50);
      dWEN    = ($urandom_range(99) < 30);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      r = $urandom_range(99);
      ramstate = (r < 20) ? FREE : (r < 60) ? BUSY : (r < 98) ? ACCESS : ERROR;

      e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0; grant = 1'b0;
      e_addr = '0; e_store = '0;
      if (m_owner == 1) begin
        grant   = 1'b1;
        e_addr  = daddr;
        e_store = dstore;
        e_wen   = dWEN;
        e_ren   = dREN && !dWEN;
        if ((dREN || dWEN) && ramstate == ACCESS) e_dw = 1'b0;
      end else if (m_owner == 2) begin
        grant  = 1'b1;
        e_addr = iaddr;
        e_ren  = 1'b1;
        if (iREN && ramstate == ACCESS) e_iw = 1'b0;
      end
      #1;
      check_outs($sformatf("rnd%0d", n), e_iw, e_dw, e_ren, e_wen, m_err, grant, e_addr,
                 e_store);

      if (m_owner == 0) begin
        if ((dREN || dWEN) && iREN) m_owner = m_last_data ? 2 : 1;
        else if (dREN || dWEN)      m_owner = 1;
        else if (iREN)              m_owner = 2;
      end else begin
        rq = (m_owner == 1) ? (dREN || dWEN) : iREN;
        if (!rq) begin
          m_owner = 0;
        end else if (ramstate == ERROR) begin
          m_err   = 1'b1;
          m_owner = 0;
        end else if (ramstate == ACCESS) begin
          m_last_data = (m_owner == 1);
          m_owner     = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= int'(TO)) begin
            m_err   = 1'b1;
            m_owner = 0;
          end
        end
      end
      if (m_owner == 0) m_cnt = 0;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
